// File: rtl/ifu_prefetch.sv
// ---------------------------------------------------------------------------
// ifu_prefetch -- instruction-fetch front end with a request/grant memory
// port and a small in-order prefetch queue feeding decode.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_flush, i_flush_pc   redirect: drop queued and in-flight fetches, restart
//                         fetching at i_flush_pc (low two bits ignored)
//   o_mem_req/o_mem_addr  fetch request and word-aligned address
//   i_mem_gnt             request accepted this cycle (qualified by o_mem_req)
//   i_mem_rvalid/rdata    in-order read response, at least 1 cycle after grant
//   o_ins_valid/o_ins/o_pc  queue head presented to decode
//   i_ins_ready           decode takes the head this cycle
//
// DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module ifu_prefetch #(
    parameter int                    CPU_WIDTH = 64,
    parameter int                    DEPTH     = 4,
    parameter logic [CPU_WIDTH-1:0]  RST_PC    = CPU_WIDTH'('h8000_0000)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_flush,
    input  logic [CPU_WIDTH-1:0] i_flush_pc,
    output logic                 o_mem_req,
    output logic [CPU_WIDTH-1:0] o_mem_addr,
    input  logic                 i_mem_gnt,
    input  logic                 i_mem_rvalid,
    input  logic [31:0]          i_mem_rdata,
    output logic                 o_ins_valid,
    output logic [31:0]          o_ins,
    output logic [CPU_WIDTH-1:0] o_pc,
    input  logic                 i_ins_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Wide enough to hold count + outstanding + drop_cnt without wrapping.
    localparam int SUM_W = CNT_W + 2;

    localparam logic [SUM_W-1:0]     DEPTH_S = SUM_W'(DEPTH);
    localparam logic [CPU_WIDTH-1:0] PC_STEP = CPU_WIDTH'(4);
    localparam logic [CPU_WIDTH-1:0] PC_MASK = ~CPU_WIDTH'(3);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [CPU_WIDTH-1:0] fetch_pc;     // next address to request
    logic [CPU_WIDTH-1:0] resp_pc;      // PC of the next kept response
    logic [CNT_W-1:0]     count;        // valid queue entries
    logic [CNT_W-1:0]     outstanding;  // granted, response still to come, kept
    logic [CNT_W-1:0]     drop_cnt;     // granted before a flush, to discard
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    // Holds the request low while reset is asserted and for the first cycle
    // after release, so o_mem_req reads 0 during reset.
    logic                 run_q;

    logic [31:0]          q_ins [DEPTH];
    logic [CPU_WIDTH-1:0] q_pc  [DEPTH];

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    logic [SUM_W-1:0]     credit_used;
    logic                 mem_req;
    logic                 grant;
    logic                 resp_drop;
    logic                 resp_push;
    logic                 pop;
    logic [CNT_W-1:0]     in_flight;
    logic [CNT_W-1:0]     flush_drop;
    logic [CPU_WIDTH-1:0] flush_target;

    // Every slot that could still land in the queue, including responses
    // that will be thrown away, holds a credit. Keeping the total at or
    // below DEPTH means a push can never find the queue full, even when the
    // push coincides with a pop.
    assign credit_used = SUM_W'(count) + SUM_W'(outstanding) + SUM_W'(drop_cnt);
    assign mem_req     = run_q && !i_flush && (credit_used < DEPTH_S);
    assign grant       = mem_req && i_mem_gnt;

    // Stale responses are consumed first because memory answers in order.
    // A response with nothing pending at all is a protocol error and is
    // ignored, which also covers responses to requests issued before reset.
    assign resp_drop   = i_mem_rvalid && (drop_cnt != '0);
    assign resp_push   = i_mem_rvalid && (drop_cnt == '0) && (outstanding != '0);
    assign pop         = (count != '0) && i_ins_ready;

    // On a flush everything still in the memory pipe becomes stale; a
    // response arriving in the flush cycle itself already retires one.
    assign in_flight   = drop_cnt + outstanding;
    assign flush_drop  = (i_mem_rvalid && (in_flight != '0)) ? in_flight - CNT_W'(1)
                                                             : in_flight;
    assign flush_target = i_flush_pc & PC_MASK;

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            run_q       <= 1'b0;
            fetch_pc    <= RST_PC;
            resp_pc     <= RST_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            // NOTE: the queue storage is reset as well; with only DEPTH
            // entries this is cheap and it gives o_ins/o_pc defined reset
            // values instead of X.
            for (int i = 0; i < DEPTH; i++) begin
                q_ins[i] <= '0;
                q_pc[i]  <= RST_PC;
            end
        end else begin
            run_q <= 1'b1;

            if (i_flush) begin
                // Redirect wins over everything else this cycle, including
                // a pop by decode and any push from a response.
                count       <= '0;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                outstanding <= '0;
                drop_cnt    <= flush_drop;
                fetch_pc    <= flush_target;
                resp_pc     <= flush_target;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end

                // Grant and kept response in the same cycle cancel out.
                case ({grant, resp_push})
                    2'b10:   outstanding <= outstanding + CNT_W'(1);
                    2'b01:   outstanding <= outstanding - CNT_W'(1);
                    default: outstanding <= outstanding;
                endcase

                if (resp_drop) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end

                if (resp_push) begin
                    q_ins[wr_ptr] <= i_mem_rdata;
                    q_pc[wr_ptr]  <= resp_pc;
                    wr_ptr        <= wr_ptr + PTR_W'(1);
                    resp_pc       <= resp_pc + PC_STEP;
                end

                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end

                case ({resp_push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The head is read straight from the queue registers; a response is
    // visible to decode the cycle after it arrives (no bypass path).
    assign o_mem_req   = mem_req;
    assign o_mem_addr  = fetch_pc;
    assign o_ins_valid = (count != '0);
    assign o_ins       = q_ins[rd_ptr];
    assign o_pc        = q_pc[rd_ptr];

endmodule

// File: tb/tb_ifu_prefetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_prefetch -- self-checking bench for ifu_prefetch.
// A cycle-stepping task plays an in-order memory with configurable latency
// and grant, and a scoreboard queue holds the {pc, ins} pairs decode should
// see; flushes and resets clear it so any stale delivery shows up.
// ---------------------------------------------------------------------------
module tb_ifu_prefetch;

    localparam int          CW     = 64;
    localparam int          DEPTH  = 4;
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_flush;
    logic [CW-1:0] i_flush_pc;
    logic          o_mem_req;
    logic [CW-1:0] o_mem_addr;
    logic          i_mem_gnt;
    logic          i_mem_rvalid;
    logic [31:0]   i_mem_rdata;
    logic          o_ins_valid;
    logic [31:0]   o_ins;
    logic [CW-1:0] o_pc;
    logic          i_ins_ready;

    ifu_prefetch #(
        .CPU_WIDTH (CW),
        .DEPTH     (DEPTH),
        .RST_PC    (RST_PC)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (i_flush),
        .i_flush_pc   (i_flush_pc),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata),
        .o_ins_valid  (o_ins_valid),
        .o_ins        (o_ins),
        .o_pc         (o_pc),
        .i_ins_ready  (i_ins_ready)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Memory requests in flight and scoreboard of expected deliveries.
    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
        int          due;
    } pend_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } exp_t;

    typedef struct {
        logic [63:0] flush_pc;
        logic [63:0] exp_addr;
        int          lat;
    } flush_vec_t;

    pend_t       pend[$];
    exp_t        exp_q[$];
    flush_vec_t  vecs[4];

    int          checks;
    int          failures;
    int          cyc;
    int          epoch;
    int          lat;
    int          n_grant;
    int          n_deliv;
    bit          ctl_flush;
    bit          ctl_ready;
    bit          ctl_gnt;
    logic [63:0] ctl_flush_pc;
    logic [63:0] exp_fetch;
    logic [63:0] last_grant_addr;
    logic [63:0] last_deliv_pc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction word returned for an address; the epoch makes words from
    // before a flush/reset distinguishable from later fetches of the same PC.
    function automatic logic [31:0] ins_of(input logic [63:0] a, input int ep);
        logic [31:0] e;
        e = ep;
        return a[31:0] ^ (e * 32'h9E37_79B9) ^ 32'h0000_1357;
    endfunction

    // One clock cycle: drive inputs, let combinational outputs settle, score
    // the handshakes of this cycle, then advance to the next falling edge.
    task automatic step();
        pend_t p;
        exp_t  e;
        i_flush     = ctl_flush;
        i_flush_pc  = ctl_flush_pc;
        i_ins_ready = ctl_ready;
        i_mem_gnt   = ctl_gnt;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            p            = pend.pop_front();
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = p.data;
        end else begin
            i_mem_rvalid = 1'b0;
            i_mem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        if (i_rst_n) begin
            if (o_ins_valid && i_ins_ready && !i_flush) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_delivery: got pc %h expected none", o_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("deliver_pc", o_pc, e.pc);
                    check("deliver_ins", {32'b0, o_ins}, {32'b0, e.ins});
                end
                n_deliv++;
                last_deliv_pc = o_pc;
            end
            if (i_flush) begin
                check("req_low_on_flush", {63'b0, o_mem_req}, 64'd0);
                exp_q.delete();
                epoch++;
                exp_fetch = ctl_flush_pc & ~64'd3;
            end else if (o_mem_req && i_mem_gnt) begin
                check("grant_addr", o_mem_addr, exp_fetch);
                p.addr = o_mem_addr;
                p.data = ins_of(o_mem_addr, epoch);
                p.due  = cyc + lat;
                pend.push_back(p);
                e.pc  = o_mem_addr;
                e.ins = p.data;
                exp_q.push_back(e);
                exp_fetch       = exp_fetch + 64'd4;
                last_grant_addr = o_mem_addr;
                n_grant++;
            end
        end
        @(posedge i_clk);
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Assert reset mid-cycle, check outputs immediately, hold, then release.
    task automatic do_reset(input int hold, input bit clear_pend);
        i_rst_n = 1'b0;
        #1;
        check("rst_mem_req",   {63'b0, o_mem_req},   64'd0);
        check("rst_ins_valid", {63'b0, o_ins_valid}, 64'd0);
        check("rst_mem_addr",  o_mem_addr,           RST_PC);
        check("rst_ins",       {32'b0, o_ins},       64'd0);
        check("rst_pc",        o_pc,                 RST_PC);
        exp_q.delete();
        if (clear_pend) pend.delete();
        epoch++;
        exp_fetch = RST_PC;
        run(hold);
        i_rst_n = 1'b1;
    endtask

    task automatic wait_grants(input int base, input int n, input string name);
        int k;
        k = 0;
        while (n_grant - base < n && k < 40) begin
            step();
            k++;
        end
        if (n_grant - base < n) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %0d grants expected %0d", name, n_grant - base, n);
        end
    endtask

    initial begin
        int          g0;
        int          d0;
        int          k;
        logic [63:0] hold_addr;

        vecs[0] = '{flush_pc: 64'h0000_0000_8000_1002, exp_addr: 64'h0000_0000_8000_1000, lat: 3};
        vecs[1] = '{flush_pc: 64'h0000_0000_0000_0003, exp_addr: 64'h0000_0000_0000_0000, lat: 1};
        vecs[2] = '{flush_pc: 64'h0000_0000_1234_5677, exp_addr: 64'h0000_0000_1234_5674, lat: 2};
        vecs[3] = '{flush_pc: 64'hFFFF_FFFF_FFFF_FFFE, exp_addr: 64'hFFFF_FFFF_FFFF_FFFC, lat: 1};

        checks = 0; failures = 0; cyc = 0; epoch = 0; lat = 1;
        n_grant = 0; n_deliv = 0;
        ctl_flush = 0; ctl_ready = 1; ctl_gnt = 1; ctl_flush_pc = '0;
        exp_fetch = RST_PC; last_grant_addr = '0; last_deliv_pc = '0;
        i_rst_n = 1'b0; i_flush = 0; i_flush_pc = '0; i_mem_gnt = 0;
        i_mem_rvalid = 0; i_mem_rdata = '0; i_ins_ready = 0;
        @(negedge i_clk);

        // Steady streaming: 1-cycle memory, decode always ready.
        lat = 1; ctl_ready = 1; ctl_gnt = 1;
        do_reset(2, 1);
        g0 = n_grant;
        step();
        step();
        check("first_grant_addr", last_grant_addr, RST_PC);
        run(8);
        d0 = n_deliv;
        run(10);
        check("steady_throughput", n_deliv - d0, 10);
        check("steady_valid", {63'b0, o_ins_valid}, 64'd1);
        check("steady_addr", o_mem_addr, exp_fetch);
        check("steady_pc_lag", o_pc, exp_fetch - 64'd8);

        // Decode stalled: credit stops fetch after DEPTH grants.
        ctl_ready = 0;
        do_reset(2, 1);
        g0 = n_grant;
        run(12);
        check("stall_grants", n_grant - g0, DEPTH);
        check("stall_req_low", {63'b0, o_mem_req}, 64'd0);
        check("stall_valid", {63'b0, o_ins_valid}, 64'd1);
        check("stall_head_pc", o_pc, RST_PC);
        ctl_ready = 1;
        g0 = n_grant;
        wait_grants(g0, 1, "resume");
        check("resume_addr", last_grant_addr, RST_PC + 64'h10);
        run(10);
        check("resume_drained", n_deliv - d0 >= 14 ? 64'd1 : 64'd0, 64'd1);

        // Redirect table: flush with two fetches in flight.
        for (int v = 0; v < 4; v++) begin
            lat = vecs[v].lat; ctl_ready = 1; ctl_gnt = 1;
            do_reset(2, 1);
            g0 = n_grant;
            wait_grants(g0, 2, "pre_flush");
            ctl_flush = 1; ctl_flush_pc = vecs[v].flush_pc;
            step();
            ctl_flush = 0;
            check("flush_addr", o_mem_addr, vecs[v].exp_addr);
            check("flush_valid_drop", {63'b0, o_ins_valid}, 64'd0);
            d0 = n_deliv;
            k = 0;
            while (n_deliv == d0 && k < 30) begin
                step();
                k++;
            end
            check("flush_first_pc", last_deliv_pc, vecs[v].exp_addr);
            run(8);
        end

        // Grant withheld for 5 cycles: request and address held.
        lat = 1; ctl_ready = 1; ctl_gnt = 1;
        do_reset(2, 1);
        run(5);
        ctl_gnt = 0;
        hold_addr = exp_fetch;
        for (int i = 0; i < 5; i++) begin
            check("nogrant_req", {63'b0, o_mem_req}, 64'd1);
            check("nogrant_addr", o_mem_addr, hold_addr);
            step();
        end
        ctl_gnt = 1;
        step();
        check("grant6_addr", o_mem_addr, hold_addr + 64'd4);
        run(6);

        // Credit-full: pop coincides with the last response being pushed.
        lat = 2; ctl_ready = 0; ctl_gnt = 1;
        do_reset(2, 1);
        g0 = n_grant;
        k = 0;
        while (!(n_grant - g0 == DEPTH && pend.size() == 1 && pend[0].due <= cyc) && k < 30) begin
            step();
            k++;
        end
        check("full_setup", (n_grant - g0 == DEPTH && pend.size() == 1) ? 64'd1 : 64'd0, 64'd1);
        d0 = n_deliv;
        ctl_ready = 1;
        step();
        ctl_ready = 0;
        check("full_pop_count", n_deliv - d0, 1);
        check("full_pop_pc", last_deliv_pc, RST_PC);
        run(6);
        check("full_grants", n_grant - g0, DEPTH + 1);
        check("full_req_low", {63'b0, o_mem_req}, 64'd0);
        check("full_head_pc", o_pc, RST_PC + 64'd4);
        ctl_ready = 1;
        run(12);

        // Reset mid-stream with two fetches outstanding; their late
        // responses must not reach decode.
        lat = 3; ctl_ready = 1; ctl_gnt = 1;
        do_reset(2, 1);
        g0 = n_grant;
        wait_grants(g0, 2, "pre_reset");
        ctl_gnt = 0;
        do_reset(1, 0);
        k = 0;
        while (pend.size() != 0 && k < 10) begin
            step();
            k++;
        end
        check("stale_drained", pend.size(), 0);
        check("stale_no_valid", {63'b0, o_ins_valid}, 64'd0);
        ctl_gnt = 1;
        g0 = n_grant;
        wait_grants(g0, 1, "restart");
        check("restart_addr", last_grant_addr, RST_PC);
        d0 = n_deliv;
        run(10);
        check("restart_delivered", n_deliv - d0 > 0 ? 64'd1 : 64'd0, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
